// File: rtl/prpg_lfsr_if.sv
// Control and observation bundle for the prpg_lfsr pattern generator.
// master drives step/load/mode controls, slave (the generator) returns state and period.
interface prpg_lfsr_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic             mode;
    logic [WIDTH-1:0] seq;
    logic             msb;
    logic             wrap;
    logic [WIDTH-1:0] period;

    modport master (
        output en, load, seed_in, mode,
        input  seq, msb, wrap, period
    );

    modport slave (
        input  en, load, seed_in, mode,
        output seq, msb, wrap, period
    );
endinterface

// File: rtl/prpg_lfsr.sv
// Fibonacci/Galois LFSR pattern generator with seed load, zero-seed guard
// and a built-in period monitor that measures the sequence length in hardware.
module prpg_lfsr #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] FIB_TAPS = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] GAL_TAPS = WIDTH'(8'h71),
    parameter logic [WIDTH-1:0] SEED     = {WIDTH{1'b1}}
) (
    input logic        clk,
    input logic        ini_n,
    prpg_lfsr_if.slave bus
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             wrap_q, wrap_d;

    logic             fib_fb;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] load_val;
    logic             cnt_sat;

    // Candidate next states for both feedback styles; mode_q picks one.
    always_comb begin
        fib_fb    = ^(state_q & FIB_TAPS);
        fib_next  = {state_q[WIDTH-2:0], fib_fb};
        gal_next  = {state_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{state_q[WIDTH-1]}} & GAL_TAPS);
        step_next = mode_q ? gal_next : fib_next;
        load_val  = (bus.seed_in == '0) ? SEED : bus.seed_in;
        cnt_sat   = (cnt_q == CNT_MAX);
    end

    // Next-state: load > mode change > step > hold.
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        mode_d   = mode_q;
        wrap_d   = 1'b0;

        if (bus.load) begin
            state_d = load_val;
            start_d = load_val;
            cnt_d   = '0;
        end else if (bus.mode != mode_q) begin
            // Switching polynomial invalidates the running measurement; restart from here.
            mode_d  = bus.mode;
            start_d = state_q;
            cnt_d   = '0;
        end else if (bus.en) begin
            state_d = step_next;
            if (step_next == start_q && !cnt_sat) begin
                wrap_d   = 1'b1;
                period_d = cnt_q + CNT_ONE;
                cnt_d    = '0;
            end else if (!cnt_sat) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge ini_n) begin
        if (!ini_n) begin
            state_q  <= SEED;
            start_q  <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.seq    = state_q;
    assign bus.msb    = state_q[WIDTH-1];
    assign bus.wrap   = wrap_q;
    assign bus.period = period_q;

endmodule

// File: tb/tb_prpg_lfsr.sv
// Scoreboard bench for prpg_lfsr (WIDTH=4): driver queues hand-computed
// expectations per cycle, a monitor pops and compares them as outputs appear.
module tb_prpg_lfsr;

    logic clk;
    logic ini_n;
    int   cyc;
    int   ph;
    int   n_checks;
    int   n_errors;

    prpg_lfsr_if #(.WIDTH(4)) b0 ();
    prpg_lfsr_if #(.WIDTH(4)) b1 ();

    assign b1.en      = b0.en;
    assign b1.load    = b0.load;
    assign b1.seed_in = b0.seed_in;
    assign b1.mode    = b0.mode;

    prpg_lfsr #(.WIDTH(4), .FIB_TAPS(4'hC), .GAL_TAPS(4'h3), .SEED(4'hF)) u0 (
        .clk  (clk),
        .ini_n(ini_n),
        .bus  (b0.slave)
    );

    // Non-maximal Fibonacci taps: cycle length 5 from F.
    prpg_lfsr #(.WIDTH(4), .FIB_TAPS(4'hF), .GAL_TAPS(4'h3), .SEED(4'hF)) u1 (
        .clk  (clk),
        .ini_n(ini_n),
        .bus  (b1.slave)
    );

    typedef struct {
        int         tgt;
        int         ph;
        logic [3:0] seq;
        logic       wrap;
        logic [3:0] period;
        logic       chk1;
        logic [3:0] seq1;
        logic       wrap1;
        logic [3:0] period1;
    } exp_t;

    exp_t sb[$];

    logic [3:0] fib_tbl  [15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                                  4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};
    logic [3:0] gal_tbl  [15] = '{4'hF, 4'hD, 4'h9, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3,
                                  4'h6, 4'hC, 4'hB, 4'h5, 4'hA, 4'h7, 4'hE};
    logic [3:0] fibf_tbl [5]  = '{4'hF, 4'hE, 4'hD, 4'hB, 4'h7};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int p, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s (phase %0d, cycle %0d): got %0h, expected %0h", name, p, cyc, act, req);
        end
    endtask

    // Monitor: reset values on async assertion, queued expectations after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge ini_n);
            if (!ini_n) begin
                #1;
                check("rst_seq",    ph, 32'(b0.seq),    32'hF);
                check("rst_msb",    ph, 32'(b0.msb),    32'h1);
                check("rst_wrap",   ph, 32'(b0.wrap),   32'h0);
                check("rst_period", ph, 32'(b0.period), 32'h0);
                check("rst_seq1",   ph, 32'(b1.seq),    32'hF);
            end else begin
                #2;
                while (sb.size() != 0 && sb[0].tgt <= cyc) begin
                    e = sb.pop_front();
                    check("sched", e.ph, 32'(e.tgt), 32'(cyc));
                    check("seq",    e.ph, 32'(b0.seq),    32'(e.seq));
                    check("msb",    e.ph, 32'(b0.msb),    32'(e.seq[3]));
                    check("wrap",   e.ph, 32'(b0.wrap),   32'(e.wrap));
                    check("period", e.ph, 32'(b0.period), 32'(e.period));
                    if (e.chk1) begin
                        check("seq_nonmax",    e.ph, 32'(b1.seq),    32'(e.seq1));
                        check("wrap_nonmax",   e.ph, 32'(b1.wrap),   32'(e.wrap1));
                        check("period_nonmax", e.ph, 32'(b1.period), 32'(e.period1));
                    end
                end
            end
        end
    end

    task automatic drive(input logic en, input logic ld, input logic [3:0] sd, input logic md,
                         input logic [3:0] es, input logic ew, input logic [3:0] ep,
                         input logic c1, input logic [3:0] es1, input logic ew1, input logic [3:0] ep1);
        exp_t e;
        b0.en      = en;
        b0.load    = ld;
        b0.seed_in = sd;
        b0.mode    = md;
        e.tgt     = cyc + 1;
        e.ph      = ph;
        e.seq     = es;
        e.wrap    = ew;
        e.period  = ep;
        e.chk1    = c1;
        e.seq1    = es1;
        e.wrap1   = ew1;
        e.period1 = ep1;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        b0.en      = 1'b0;
        b0.load    = 1'b0;
        b0.seed_in = 4'h0;
        b0.mode    = 1'b0;
        ini_n      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ini_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        ph         = 0;
        ini_n      = 1'b1;
        b0.en      = 1'b0;
        b0.load    = 1'b0;
        b0.seed_in = 4'h0;
        b0.mode    = 1'b0;
        #2;
        pulse_reset();

        // Fibonacci free-run, two full periods, with the non-maximal twin alongside.
        ph = 1;
        for (int i = 1; i <= 31; i++) begin
            drive(1'b1, 1'b0, 4'h0, 1'b0,
                  fib_tbl[i % 15], (i % 15) == 0, (i >= 15) ? 4'hF : 4'h0,
                  1'b1, fibf_tbl[i % 5], (i % 5) == 0, (i >= 5) ? 4'h5 : 4'h0);
        end

        // Zero load with en: substitute SEED, no step; then seed 5 and run to its return.
        ph = 2;
        drive(1'b1, 1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0);
        drive(1'b0, 1'b1, 4'h5, 1'b0, 4'h5, 1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0);
        for (int i = 1; i <= 15; i++) begin
            drive(1'b1, 1'b0, 4'h0, 1'b0, fib_tbl[(12 + i) % 15], i == 15, 4'hF,
                  1'b0, 4'h0, 1'b0, 4'h0);
        end

        // Enable gating: 15 enabled steps spread over 30 clocks.
        ph = 3;
        k  = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) k++;
            drive((i % 2) == 0, 1'b0, 4'h0, 1'b0, fib_tbl[(12 + k) % 15],
                  ((i % 2) == 0) && (k == 15), 4'hF, 1'b0, 4'h0, 1'b0, 4'h0);
        end

        // Abort mid-measurement with reset, then measure from SEED again.
        ph = 4;
        for (int i = 1; i <= 7; i++) begin
            drive(1'b1, 1'b0, 4'h0, 1'b0, fib_tbl[(12 + i) % 15], 1'b0, 4'hF,
                  1'b0, 4'h0, 1'b0, 4'h0);
        end
        #3;
        pulse_reset();
        for (int i = 1; i <= 15; i++) begin
            drive(1'b1, 1'b0, 4'h0, 1'b0, fib_tbl[i % 15], i == 15, (i == 15) ? 4'hF : 4'h0,
                  1'b0, 4'h0, 1'b0, 4'h0);
        end

        // Galois from reset: one idle mode-change cycle, then a full period.
        ph = 5;
        #3;
        pulse_reset();
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0);
        for (int i = 1; i <= 15; i++) begin
            drive(1'b1, 1'b0, 4'h0, 1'b1, gal_tbl[i % 15], i == 15, (i == 15) ? 4'hF : 4'h0,
                  1'b0, 4'h0, 1'b0, 4'h0);
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 4'h0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
